// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: waits for data-SRAM data_ok on issued accesses, extends load data, feeds WB and ID bypass.
// Latency: non-memory ops spend 1 cycle; an access leaves on the cycle its data_ok arrives, or later from rbuf.
// Backpressure: holds the entry while wb_allowin is low; a response arriving meanwhile is parked in rbuf.
module mem_stage_lsu #(
    parameter int XLEN   = 32,
    parameter int DEST_W = 5,
    parameter int DISC_W = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           exe_mem_valid,
    output logic                           mem_allowin,
    input  logic [6+DEST_W+3*XLEN-1:0]     exe_mem_bus,
    input  logic                           exe_inflight_cancel,
    input  logic                           flush,
    output logic                           mem_wb_valid,
    input  logic                           wb_allowin,
    output logic [1+3*XLEN+DEST_W-1:0]     mem_wb_bus,
    input  logic                           data_sram_data_ok,
    input  logic [XLEN-1:0]                data_sram_rdata,
    output logic [2+DEST_W+XLEN-1:0]       mem_fwd_bus
);

    // Sum width leaves headroom for counter + two increments before saturation.
    localparam int SUM_W = DISC_W + 2;
    localparam logic [SUM_W-1:0] DISC_MAX = SUM_W'((1 << DISC_W) - 1);

    // Field layout of the EXE->MEM bus, MSB first.
    typedef struct packed {
        logic              gr_we;
        logic              res_from_mem;
        logic [2:0]        ld_op;
        logic              req_issued;
        logic [DEST_W-1:0] dest;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   inst;
        logic [XLEN-1:0]   alu_result;
    } exe_bus_t;

    // Stage state.
    logic              mem_valid_q,  mem_valid_d;
    exe_bus_t          bus_q,        bus_d;
    logic [XLEN-1:0]   rbuf_q,       rbuf_d;
    logic              rbuf_valid_q, rbuf_valid_d;
    logic [DISC_W-1:0] disc_cnt_q,   disc_cnt_d;

    // Handshake and datapath intermediates.
    logic              resp_live;
    logic              resp_drop;
    logic              waiting;
    logic              mem_ready_go;
    logic              mem_leave;
    logic              capture;
    logic              park_resp;
    logic [SUM_W-1:0]  disc_sum;
    logic [XLEN-1:0]   ld_raw;
    logic [XLEN-1:0]   ld_shift;
    logic [XLEN-1:0]   ld_ext;
    logic [XLEN-1:0]   final_result;
    logic              fwd_we;
    logic              fwd_ready;

    // Response classification and stage handshake.
    always_comb begin
        // A response only belongs to the current entry once all stale ones are drained.
        resp_live    = data_sram_data_ok & (disc_cnt_q == '0);
        resp_drop    = data_sram_data_ok & (disc_cnt_q != '0);
        waiting      = mem_valid_q & bus_q.req_issued & ~rbuf_valid_q;
        mem_ready_go = ~bus_q.req_issued | rbuf_valid_q | (waiting & resp_live);
        mem_wb_valid = mem_valid_q & mem_ready_go & ~flush;
        mem_allowin  = ~mem_valid_q | (mem_ready_go & wb_allowin);
        mem_leave    = mem_wb_valid & wb_allowin;
        capture      = exe_mem_valid & mem_allowin & ~flush;
        // Response is consumed but WB cannot take it yet: keep it for a later cycle.
        park_resp    = waiting & resp_live & ~wb_allowin;
    end

    // Valid bit and bus register next state; flush kills the entry and blocks capture.
    always_comb begin
        mem_valid_d = mem_valid_q;
        bus_d       = bus_q;
        if (flush) begin
            mem_valid_d = 1'b0;
        end else if (mem_allowin) begin
            mem_valid_d = exe_mem_valid;
        end
        if (capture) begin
            bus_d = exe_mem_bus;
        end
    end

    // Response buffer: filled when data arrives under WB backpressure, emptied when the entry leaves.
    always_comb begin
        rbuf_d       = rbuf_q;
        rbuf_valid_d = rbuf_valid_q;
        if (flush) begin
            rbuf_valid_d = 1'b0;
        end else if (mem_leave) begin
            rbuf_valid_d = 1'b0;
        end else if (park_resp) begin
            rbuf_valid_d = 1'b1;
            rbuf_d       = data_sram_rdata;
        end
    end

    // Discard counter: on flush, add outstanding responses that must be thrown away; drain on each dropped data_ok.
    always_comb begin
        disc_sum = SUM_W'(disc_cnt_q)
                 - SUM_W'(resp_drop);
        if (flush) begin
            // A live response arriving with the flush is consumed here, so it is not counted.
            disc_sum = disc_sum
                     + SUM_W'(waiting & ~resp_live)
                     + SUM_W'(exe_inflight_cancel);
        end
        if (disc_sum > DISC_MAX) begin
            disc_cnt_d = DISC_MAX[DISC_W-1:0];
        end else begin
            disc_cnt_d = disc_sum[DISC_W-1:0];
        end
    end

    // Load alignment and extension; unlisted ld_op encodings fall back to a full word.
    always_comb begin
        ld_raw   = rbuf_valid_q ? rbuf_q : data_sram_rdata;
        ld_shift = ld_raw >> {bus_q.alu_result[1:0], 3'b000};
        case (bus_q.ld_op)
            3'b001:  ld_ext = {{(XLEN-8){ld_shift[7]}},  ld_shift[7:0]};
            3'b010:  ld_ext = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
            3'b011:  ld_ext = {{(XLEN-8){1'b0}},          ld_shift[7:0]};
            3'b100:  ld_ext = {{(XLEN-16){1'b0}},         ld_shift[15:0]};
            default: ld_ext = ld_shift;
        endcase
        final_result = bus_q.res_from_mem ? ld_ext : bus_q.alu_result;
    end

    // Result buses to WB and to the ID bypass/stall logic.
    always_comb begin
        fwd_we      = mem_valid_q & bus_q.gr_we;
        fwd_ready   = mem_ready_go;
        mem_wb_bus  = {bus_q.gr_we, bus_q.pc, bus_q.inst, final_result, bus_q.dest};
        mem_fwd_bus = {fwd_we, fwd_ready, bus_q.dest, final_result};
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid_q  <= 1'b0;
            bus_q        <= '0;
            rbuf_q       <= '0;
            rbuf_valid_q <= 1'b0;
            disc_cnt_q   <= '0;
        end else begin
            mem_valid_q  <= mem_valid_d;
            bus_q        <= bus_d;
            rbuf_q       <= rbuf_d;
            rbuf_valid_q <= rbuf_valid_d;
            disc_cnt_q   <= disc_cnt_d;
        end
    end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Next-generation MEM pipeline stage for the five-stage CPU. It accepts the EXE→MEM bus, waits for the data-SRAM response on the request/`data_ok` interface when the instruction issued a load or store in EXE, and sign- or zero-extends sub-word load data. It forwards the result to WB and to the ID bypass/stall logic. On a flush it discards responses still in flight, so a cancelled load's data never reaches the register file.

## Interface
Parameters:
- `XLEN`, 32: data, PC and instruction width.
- `DEST_W`, 5: register index width.
- `DISC_W`, 2: width of the discard counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `exe_mem_valid`  in  1  EXE holds a valid instruction.
- `mem_allowin`  out  1  MEM accepts a new entry this cycle.
- `exe_mem_bus`  in  6+DEST_W+3·XLEN  fields, MSB first: `{gr_we, res_from_mem, ld_op[2:0], req_issued, dest, pc, inst, alu_result}`.
- `exe_inflight_cancel`  in  1  asserted with `flush`: EXE has an accepted request whose `data_ok` has not yet returned.
- `flush`  in  1  exception or ertn flush.
- `mem_wb_valid`  out  1  MEM presents a finished instruction.
- `wb_allowin`  in  1  WB accepts.
- `mem_wb_bus`  out  1+3·XLEN+DEST_W  `{gr_we, pc, inst, final_result, dest}`.
- `data_sram_data_ok`  in  1  response strobe.
- `data_sram_rdata`  in  XLEN  response data.
- `mem_fwd_bus`  out  2+DEST_W+XLEN  `{fwd_we, fwd_ready, dest, final_result}`.

## Operation
- State: `mem_valid`, the bus register, `rbuf` (XLEN) with `rbuf_valid`, and `disc_cnt` (DISC_W bits).
- Capture: the bus register loads `exe_mem_bus` when `exe_mem_valid & mem_allowin & ~flush`. `mem_valid` takes `exe_mem_valid` under the same `mem_allowin` condition.
- Flush: `mem_valid` is cleared, `rbuf_valid` is cleared, and no capture happens that cycle.
- `resp_live = data_sram_data_ok & (disc_cnt == 0)`. A `data_ok` arriving while `disc_cnt > 0` decrements the counter and its data is dropped.
- `waiting = mem_valid & req_issued & ~rbuf_valid`.
- `mem_ready_go = ~req_issued | rbuf_valid | (waiting & resp_live)`.
- `mem_wb_valid = mem_valid & mem_ready_go & ~flush`.
- `mem_allowin = ~mem_valid | (mem_ready_go & wb_allowin)`.
- Buffering: if `waiting & resp_live & ~wb_allowin`, `rdata` is latched into `rbuf` and `rbuf_valid` is set. `rbuf_valid` clears when the entry leaves MEM.
- Load data is `rbuf_valid ? rbuf : data_sram_rdata`. It is shifted right by `8·alu_result[1:0]` and then extended by `ld_op`:
  - 000: ld.w.
  - 001: ld.b, sign-extend bit 7.
  - 010: ld.h, sign-extend bit 15.
  - 011: ld.bu, zero-extend.
  - 100: ld.hu, zero-extend.
  - Other `ld_op` values behave as ld.w.
- `final_result = res_from_mem ? extended : alu_result`.
- Discard counter update on flush: `disc_cnt` gains `(waiting & ~resp_live) + exe_inflight_cancel`, minus 1 if a `data_ok` is dropped that cycle. The update saturates at 2^DISC_W−1.
- Simultaneous `flush` and live `data_ok` for the waiting entry: that response is consumed and discarded, so it does not count toward `disc_cnt`.
- Forwarding:
  - `fwd_we = mem_valid & gr_we`.
  - `fwd_ready = mem_ready_go`. ID stalls on a dest match while `fwd_ready = 0`.

## Timing
- Reset values:
  - Registers: `mem_valid = 0`, `rbuf_valid = 0`, `disc_cnt = 0`.
  - Outputs: `mem_allowin = 1`, `mem_wb_valid = 0`, `fwd_we = 0`.
- Non-memory instruction: 1 cycle in MEM when `wb_allowin = 1`.
- Load: `data_ok` is used combinationally in the same cycle it arrives. The instruction leaves at the same edge if WB allows; otherwise it leaves from `rbuf` on a later cycle with no further SRAM wait.
- Back-to-back throughput: 1 instruction per cycle when responses arrive every cycle.
- Reset during a wait clears everything. A `data_ok` that arrives after reset is dropped by the bus master, not by this block.

## Test plan
- ALU instruction: `gr_we = 1`, `dest = 7`, `alu_result = 0x1234_5678`, `wb_allowin = 1` → next cycle `mem_wb_valid = 1`, `final_result = 0x1234_5678`, `mem_allowin = 1`.
- ld.b at `alu_result[1:0] = 2'b11`, `rdata = 0x80FF_0000`, `data_ok` two cycles late → `mem_wb_valid` low for 2 cycles with `fwd_ready = 0`, then `final_result = 0xFFFF_FF80`. Same case with ld.bu → `0x0000_0080`; ld.hu at offset 2 → `0x0000_80FF`.
- Load whose `data_ok` arrives while `wb_allowin = 0` for 3 cycles → `rbuf` holds the data, `mem_wb_valid` stays high, and the correct result is delivered when `wb_allowin` rises.
- `flush` while a load is waiting and `exe_inflight_cancel = 1` → `disc_cnt = 2`. The next two `data_ok` are dropped with `mem_wb_valid = 0`. The third `data_ok` completes the next load.
- `flush` in the same cycle as a live `data_ok` → `disc_cnt` stays 0 and `mem_wb_valid = 0`.
- `reset` asserted mid-wait → next cycle `mem_valid = 0`, `disc_cnt = 0`, `mem_allowin = 1`.
